// File: rtl/video_pkg.sv
// Shared video-path constants and the byte-pairing FSM encoding.
package video_pkg;

    localparam int unsigned OV7670_H_ACTIVE = 640;
    localparam int unsigned OV7670_V_ACTIVE = 480;
    localparam int unsigned PIXEL_W         = 16;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        BYTE_HI  = 2'd1,
        BYTE_LO  = 2'd2
    } framer_state_e;

endpackage

// File: rtl/rgb565_pixel_framer_if.sv
// Camera byte stream in, framed RGB565 pixel stream out.
interface rgb565_pixel_framer_if;
    import video_pkg::*;

    logic [7:0]         s_tdata;
    logic               s_tvalid;
    logic               s_tready;
    logic [PIXEL_W-1:0] m_tdata;
    logic               m_tvalid;
    logic               m_tready;
    logic               m_tuser;
    logic               m_tlast;

    // slave: the framer's view; master: the surrounding system's view
    modport slave (
        input  s_tdata, s_tvalid, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tuser, m_tlast
    );

    modport master (
        output s_tdata, s_tvalid, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tuser, m_tlast
    );

endinterface

// File: rtl/axis_out_reg.sv
// One-deep AXI-Stream output slice holding {tdata, tuser, tlast} until accepted.
module axis_out_reg
    import video_pkg::*;
#(
    parameter int unsigned W = PIXEL_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] tdata_i,
    input  logic         tuser_i,
    input  logic         tlast_i,
    input  logic         tready_i,
    output logic         tvalid_o,
    output logic [W-1:0] tdata_o,
    output logic         tuser_o,
    output logic         tlast_o
);

    logic         valid_q;
    logic [W-1:0] data_q;
    logic         user_q;
    logic         last_q;

    // Caller only loads when the slot is empty or being drained this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            user_q  <= 1'b0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= tdata_i;
            user_q  <= tuser_i;
            last_q  <= tlast_i;
        end else if (tready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign tvalid_o = valid_q;
    assign tdata_o  = data_q;
    assign tuser_o  = user_q;
    assign tlast_o  = last_q;

endmodule

// File: rtl/rgb565_pixel_framer.sv
// Pairs OV7670 bytes into RGB565 pixels and frames them with tuser/tlast, realigning on sof.
module rgb565_pixel_framer
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = OV7670_H_ACTIVE,
    parameter int unsigned V_ACTIVE = OV7670_V_ACTIVE
) (
    input  logic                        clk,
    input  logic                        RESETn,
    input  logic                        sof,
    rgb565_pixel_framer_if.slave        bus,
    output logic                        frame_done,
    output logic                        resync,
    output logic [15:0]                 frame_count
);

    localparam int unsigned XW = $clog2(H_ACTIVE);
    localparam int unsigned YW = $clog2(V_ACTIVE);
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    framer_state_e state_q, state_d;
    logic [7:0]    hi_q, hi_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          pend_q, pend_d;
    logic          frame_done_q, frame_done_d;
    logic          resync_q, resync_d;
    logic [15:0]   frame_count_q, frame_count_d;

    logic s_ready;
    logic byte_hs;
    logic load;
    logic accept;
    logic x_last;
    logic y_last;
    logic pix_user;

    always_comb begin
        s_ready = 1'b1;
        if (state_q == BYTE_LO) begin
            s_ready = ~bus.m_tvalid | bus.m_tready;
        end
        byte_hs  = bus.s_tvalid & s_ready & ~sof;
        load     = byte_hs & (state_q == BYTE_LO);
        accept   = bus.m_tvalid & bus.m_tready;
        x_last   = (x_q == X_LAST);
        y_last   = (y_q == Y_LAST);
        pix_user = (x_q == '0) && (y_q == '0);
    end

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        x_d      = x_q;
        y_d      = y_q;
        resync_d = 1'b0;

        if (sof) begin
            state_d  = BYTE_HI;
            hi_d     = '0;
            x_d      = '0;
            y_d      = '0;
            // Only a frame that has already consumed a byte counts as interrupted.
            resync_d = (state_q == BYTE_LO) || ((state_q == BYTE_HI) && !pix_user);
        end else begin
            case (state_q)
                WAIT_SOF: ;
                BYTE_HI: begin
                    if (byte_hs) begin
                        hi_d    = bus.s_tdata;
                        state_d = BYTE_LO;
                    end
                end
                BYTE_LO: begin
                    if (byte_hs) begin
                        state_d = BYTE_HI;
                        if (x_last) begin
                            x_d = '0;
                            if (y_last) begin
                                y_d     = '0;
                                state_d = WAIT_SOF;
                            end else begin
                                y_d = y_q + 1'b1;
                            end
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                    end
                end
                default: state_d = WAIT_SOF;
            endcase
        end
    end

    // pend tracks whether the beat currently held in the slice closes a frame.
    always_comb begin
        pend_d        = (pend_q & ~accept) | (load & x_last & y_last);
        frame_done_d  = accept & pend_q;
        frame_count_d = frame_count_q;
        if (accept && pend_q) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            state_q       <= WAIT_SOF;
            hi_q          <= '0;
            x_q           <= '0;
            y_q           <= '0;
            pend_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            resync_q      <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            hi_q          <= hi_d;
            x_q           <= x_d;
            y_q           <= y_d;
            pend_q        <= pend_d;
            frame_done_q  <= frame_done_d;
            resync_q      <= resync_d;
            frame_count_q <= frame_count_d;
        end
    end

    axis_out_reg #(
        .W (PIXEL_W)
    ) u_out (
        .clk      (clk),
        .rst_n    (RESETn),
        .load_i   (load),
        .tdata_i  ({hi_q, bus.s_tdata}),
        .tuser_i  (pix_user),
        .tlast_i  (x_last),
        .tready_i (bus.m_tready),
        .tvalid_o (bus.m_tvalid),
        .tdata_o  (bus.m_tdata),
        .tuser_o  (bus.m_tuser),
        .tlast_o  (bus.m_tlast)
    );

    assign bus.s_tready = s_ready;
    assign frame_done   = frame_done_q;
    assign resync       = resync_q;
    assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_rgb565_pixel_framer.sv
// Directed bench for rgb565_pixel_framer with a 4x2 frame geometry.
module tb_rgb565_pixel_framer;
    import video_pkg::*;

    logic        clk = 1'b0;
    logic        RESETn;
    logic        sof;
    logic        frame_done;
    logic        resync;
    logic [15:0] frame_count;

    rgb565_pixel_framer_if bus();

    rgb565_pixel_framer #(
        .H_ACTIVE (4),
        .V_ACTIVE (2)
    ) dut (
        .clk         (clk),
        .RESETn      (RESETn),
        .sof         (sof),
        .bus         (bus),
        .frame_done  (frame_done),
        .resync      (resync),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int stall_cycles = 0;

    // Monitor: everything sampled on the falling edge, away from the active edge.
    logic [17:0] pix_q[$];
    int done_cnt = 0;
    int resync_cnt = 0;
    int valid_seen = 0;

    always @(negedge clk) begin
        if (bus.m_tvalid) valid_seen++;
        if (bus.m_tvalid && bus.m_tready) pix_q.push_back({bus.m_tuser, bus.m_tlast, bus.m_tdata});
        if (frame_done) done_cnt++;
        if (resync) resync_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sof();
        sof = 1'b1;
        step();
        sof = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        bus.s_tdata  = b;
        bus.s_tvalid = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (bus.s_tready) ok = 1'b1;
            else stall_cycles++;
            @(posedge clk);
            #1;
        end
        bus.s_tvalid = 1'b0;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL send_byte_timeout byte=%h not accepted within 50 cycles", b);
        end
    endtask

    task automatic test_reset();
        RESETn = 1'b0; sof = 1'b0;
        bus.s_tvalid = 1'b0; bus.s_tdata = '0; bus.m_tready = 1'b0;
        repeat (3) step();
        checks++; if (bus.m_tvalid !== 1'b0) begin failures++; $display("FAIL rst_m_tvalid got=%b exp=0", bus.m_tvalid); end
        checks++; if (bus.m_tdata !== 16'h0000) begin failures++; $display("FAIL rst_m_tdata got=%h exp=0000", bus.m_tdata); end
        checks++; if (bus.m_tuser !== 1'b0) begin failures++; $display("FAIL rst_m_tuser got=%b exp=0", bus.m_tuser); end
        checks++; if (bus.m_tlast !== 1'b0) begin failures++; $display("FAIL rst_m_tlast got=%b exp=0", bus.m_tlast); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
        checks++; if (resync !== 1'b0) begin failures++; $display("FAIL rst_resync got=%b exp=0", resync); end
        checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL rst_frame_count got=%0d exp=0", frame_count); end
        checks++; if (bus.s_tready !== 1'b1) begin failures++; $display("FAIL rst_s_tready got=%b exp=1", bus.s_tready); end
        RESETn = 1'b1;
        step();
    endtask

    task automatic test_no_sof();
        int v0 = valid_seen;
        int s0 = stall_cycles;
        int p0 = pix_q.size();
        bus.m_tready = 1'b1;
        for (int i = 0; i < 6; i++) send_byte(8'hC0 + 8'(i));
        repeat (3) step();
        checks++; if (valid_seen !== v0) begin failures++; $display("FAIL nosof_valid got=%0d exp=%0d", valid_seen, v0); end
        checks++; if (stall_cycles !== s0) begin failures++; $display("FAIL nosof_s_tready_low got=%0d exp=%0d", stall_cycles - s0, 0); end
        checks++; if (pix_q.size() !== p0) begin failures++; $display("FAIL nosof_pixels got=%0d exp=%0d", pix_q.size() - p0, 0); end
    endtask

    task automatic test_full_frame();
        int base = pix_q.size();
        int d0 = done_cnt;
        int r0 = resync_cnt;
        int s0 = stall_cycles;
        logic [17:0] exp;
        logic [17:0] got;
        pulse_sof();
        bus.m_tready = 1'b1;
        for (int i = 0; i < 16; i++) send_byte(8'h11 + 8'(i));
        repeat (4) step();
        checks++; if (pix_q.size() - base !== 8) begin failures++; $display("FAIL frame_pix_count got=%0d exp=8", pix_q.size() - base); end
        for (int i = 0; i < 8; i++) begin
            exp = {1'(i == 0), 1'((i % 4) == 3), 8'h11 + 8'(2 * i), 8'h12 + 8'(2 * i)};
            got = (pix_q.size() > base + i) ? pix_q[base + i] : 18'hx;
            checks++; if (got !== exp) begin failures++; $display("FAIL frame_pix%0d got=%h exp=%h", i, got, exp); end
        end
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL frame_done_pulses got=%0d exp=1", done_cnt - d0); end
        checks++; if (frame_count !== 16'd1) begin failures++; $display("FAIL frame_count got=%0d exp=1", frame_count); end
        checks++; if (resync_cnt - r0 !== 0) begin failures++; $display("FAIL frame_resync got=%0d exp=0", resync_cnt - r0); end
        checks++; if (stall_cycles - s0 !== 0) begin failures++; $display("FAIL back_to_back_stalls got=%0d exp=0", stall_cycles - s0); end
    endtask

    task automatic test_stall();
        int base = pix_q.size();
        int d0 = done_cnt;
        logic [17:0] exp;
        logic [17:0] got;
        pulse_sof();
        bus.m_tready = 1'b1;
        send_byte(8'h21);
        bus.m_tready = 1'b0;
        send_byte(8'h22);
        send_byte(8'h23);
        bus.s_tdata  = 8'h24;
        bus.s_tvalid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (bus.s_tready !== 1'b0) begin failures++; $display("FAIL stall_s_tready%0d got=%b exp=0", k, bus.s_tready); end
            checks++; if (bus.m_tdata !== 16'h2122) begin failures++; $display("FAIL stall_m_tdata%0d got=%h exp=2122", k, bus.m_tdata); end
            checks++; if (bus.m_tvalid !== 1'b1) begin failures++; $display("FAIL stall_m_tvalid%0d got=%b exp=1", k, bus.m_tvalid); end
            @(posedge clk);
            #1;
        end
        bus.m_tready = 1'b1;
        for (int i = 0; i < 13; i++) send_byte(8'h24 + 8'(i));
        repeat (4) step();
        checks++; if (pix_q.size() - base !== 8) begin failures++; $display("FAIL stall_pix_count got=%0d exp=8", pix_q.size() - base); end
        for (int i = 0; i < 8; i++) begin
            exp = {1'(i == 0), 1'((i % 4) == 3), 8'h21 + 8'(2 * i), 8'h22 + 8'(2 * i)};
            got = (pix_q.size() > base + i) ? pix_q[base + i] : 18'hx;
            checks++; if (got !== exp) begin failures++; $display("FAIL stall_pix%0d got=%h exp=%h", i, got, exp); end
        end
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL stall_done_pulses got=%0d exp=1", done_cnt - d0); end
        checks++; if (frame_count !== 16'd2) begin failures++; $display("FAIL stall_frame_count got=%0d exp=2", frame_count); end
    endtask

    task automatic test_resync();
        int base = pix_q.size();
        int d0 = done_cnt;
        int r0 = resync_cnt;
        int r1;
        logic [15:0] fc0 = frame_count;
        logic [17:0] got;
        bus.m_tready = 1'b1;
        pulse_sof();
        pulse_sof();
        repeat (2) step();
        checks++; if (resync_cnt - r0 !== 0) begin failures++; $display("FAIL idle_sof_resync got=%0d exp=0", resync_cnt - r0); end
        for (int i = 0; i < 5; i++) send_byte(8'h41 + 8'(i));
        r1 = resync_cnt;
        pulse_sof();
        step();
        checks++; if (resync_cnt - r1 !== 1) begin failures++; $display("FAIL midframe_resync got=%0d exp=1", resync_cnt - r1); end
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (3) step();
        checks++; if (pix_q.size() - base !== 3) begin failures++; $display("FAIL resync_pix_count got=%0d exp=3", pix_q.size() - base); end
        got = (pix_q.size() > base) ? pix_q[base] : 18'hx;
        checks++; if (got !== {2'b10, 16'h4142}) begin failures++; $display("FAIL resync_pix0 got=%h exp=%h", got, {2'b10, 16'h4142}); end
        got = (pix_q.size() > base + 1) ? pix_q[base + 1] : 18'hx;
        checks++; if (got !== {2'b00, 16'h4344}) begin failures++; $display("FAIL resync_pix1 got=%h exp=%h", got, {2'b00, 16'h4344}); end
        got = (pix_q.size() > base + 2) ? pix_q[base + 2] : 18'hx;
        checks++; if (got !== {2'b10, 16'hAABB}) begin failures++; $display("FAIL resync_pix2 got=%h exp=%h", got, {2'b10, 16'hAABB}); end
        checks++; if (frame_count !== fc0) begin failures++; $display("FAIL resync_frame_count got=%0d exp=%0d", frame_count, fc0); end
        checks++; if (done_cnt - d0 !== 0) begin failures++; $display("FAIL resync_done got=%0d exp=0", done_cnt - d0); end
    endtask

    task automatic test_sof_stalled();
        int base;
        int r1;
        logic [17:0] got;
        bus.m_tready = 1'b1;
        pulse_sof();
        base = pix_q.size();
        send_byte(8'h11);
        send_byte(8'h22);
        step();
        bus.m_tready = 1'b0;
        send_byte(8'h33);
        send_byte(8'h44);
        r1 = resync_cnt;
        pulse_sof();
        step();
        checks++; if (resync_cnt - r1 !== 1) begin failures++; $display("FAIL stalled_sof_resync got=%0d exp=1", resync_cnt - r1); end
        checks++; if (bus.m_tvalid !== 1'b1) begin failures++; $display("FAIL stalled_sof_valid got=%b exp=1", bus.m_tvalid); end
        checks++; if (bus.m_tdata !== 16'h3344) begin failures++; $display("FAIL stalled_sof_data got=%h exp=3344", bus.m_tdata); end
        bus.m_tready = 1'b1;
        send_byte(8'h55);
        send_byte(8'h66);
        repeat (3) step();
        checks++; if (pix_q.size() - base !== 3) begin failures++; $display("FAIL stalled_pix_count got=%0d exp=3", pix_q.size() - base); end
        got = (pix_q.size() > base) ? pix_q[base] : 18'hx;
        checks++; if (got !== {2'b10, 16'h1122}) begin failures++; $display("FAIL stalled_pix0 got=%h exp=%h", got, {2'b10, 16'h1122}); end
        got = (pix_q.size() > base + 1) ? pix_q[base + 1] : 18'hx;
        checks++; if (got !== {2'b00, 16'h3344}) begin failures++; $display("FAIL stalled_pix1 got=%h exp=%h", got, {2'b00, 16'h3344}); end
        got = (pix_q.size() > base + 2) ? pix_q[base + 2] : 18'hx;
        checks++; if (got !== {2'b10, 16'h5566}) begin failures++; $display("FAIL stalled_pix2 got=%h exp=%h", got, {2'b10, 16'h5566}); end
    endtask

    task automatic test_async_reset();
        int base;
        int v0;
        logic [17:0] got;
        pulse_sof();
        bus.m_tready = 1'b0;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        #2;
        checks++; if (bus.m_tvalid !== 1'b1) begin failures++; $display("FAIL prereset_valid got=%b exp=1", bus.m_tvalid); end
        RESETn = 1'b0;
        #1;
        checks++; if (bus.m_tvalid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b exp=0", bus.m_tvalid); end
        checks++; if (bus.m_tdata !== 16'h0000) begin failures++; $display("FAIL areset_data got=%h exp=0000", bus.m_tdata); end
        checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL areset_frame_count got=%0d exp=0", frame_count); end
        checks++; if (bus.s_tready !== 1'b1) begin failures++; $display("FAIL areset_s_tready got=%b exp=1", bus.s_tready); end
        repeat (2) step();
        RESETn = 1'b1;
        step();
        base = pix_q.size();
        v0 = valid_seen;
        bus.m_tready = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(8'h70 + 8'(i));
        repeat (2) step();
        checks++; if (valid_seen !== v0) begin failures++; $display("FAIL postreset_valid got=%0d exp=%0d", valid_seen, v0); end
        pulse_sof();
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (2) step();
        checks++; if (pix_q.size() - base !== 1) begin failures++; $display("FAIL postreset_pix_count got=%0d exp=1", pix_q.size() - base); end
        got = (pix_q.size() > base) ? pix_q[base] : 18'hx;
        checks++; if (got !== {2'b10, 16'hAABB}) begin failures++; $display("FAIL postreset_pix0 got=%h exp=%h", got, {2'b10, 16'hAABB}); end
    endtask

    initial begin
        test_reset();
        test_no_sof();
        test_full_frame();
        test_stall();
        test_resync();
        test_sof_stalled();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
